sub8_pipe_stage: RTL and testbench

Registered, flow-controlled subtract stage that sits directly upstream of the 8-bit subtractor datapath consumers. It captures operand pairs under a valid/ready handshake and computes A − B − borrow-in in a second register stage. It presents the difference and borrow-out downstream with full back-pressure support and one result per cycle sustained throughput.

---
 rtl/sub8_pipe_stage.sv | 98 +++++++++
 tb/tb_sub8_pipe_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub8_pipe_stage.sv
// rtl/sub8_pipe_stage.sv - two-stage flow-controlled subtractor (a - b - bin) with borrow out
module sub8_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
);

  logic [WIDTH-1:0] a_q, b_q;
  logic             bin_q;
  logic             s1_valid_q, s1_valid_d;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             s2_valid_q, s2_valid_d;

  logic             s2_adv, s1_adv;
  logic             in_xfer, out_xfer;
  logic [WIDTH:0]   sub_full;

  // in_ready is combinational from out_ready so a full pipe refills in the release cycle
  always_comb begin
    s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    s1_adv   = ~s1_valid_q | s2_adv;
    in_xfer  = in_valid & s1_adv;
    out_xfer = s2_valid_q & out_ready;
    sub_full = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, bin_q};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid_d = 1'b1;
      end else if (s2_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s2_adv) begin
        s2_valid_d = 1'b1;
      end else if (out_xfer) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      bin_q <= 1'b0;
    end else if (in_xfer && !flush) begin
      a_q   <= in_a;
      b_q   <= in_b;
      bin_q <= in_bin;
    end
  end

  // Result registers only move on an advance, which also provides the hold under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (s2_adv && !flush) begin
      diff_q <= sub_full[WIDTH-1:0];
      bout_q <= sub_full[WIDTH];
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_diff  = diff_q;
  assign out_bout  = bout_q;

endmodule

// File: tb/tb_sub8_pipe_stage.sv
// tb/tb_sub8_pipe_stage.sv - self-checking bench for sub8_pipe_stage
module tb_sub8_pipe_stage;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, in_bin;
  logic [7:0] in_a, in_b, out_diff;
  logic       out_valid, out_ready, out_bout;

  sub8_pipe_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_bout(out_bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   check_lat = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int   d;
    d = int'(a) - int'(b) - int'(bin);
    e.bout = (d < 0);
    e.diff = 8'(d + 256);
    e.cyc  = 0;
    return e;
  endfunction

  // Observe handshakes mid-cycle: what is seen here is what the next rising edge commits
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_diff), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_diff", 32'(out_diff), 32'(e.diff));
          chk("sb_bout", 32'(out_bout), 32'(e.bout));
          if (check_lat) chk("sb_latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e = model(in_a, in_b, in_bin);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic bin);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h05, 8'h07, 1'b0, 8'hFE, 1'b1};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[6] = '{8'h20, 8'h02, 1'b1, 8'h1D, 1'b0};
    vecs[7] = '{8'h30, 8'h03, 1'b0, 8'h2D, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_bin = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_diff", 32'(out_diff), 32'd0);
    chk("rst_out_bout", 32'(out_bout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: one transaction at a time, exact 2-edge latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("tbl_not_early", 32'(out_valid), 32'd0);
      step();
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_diff", 32'(out_diff), 32'(vecs[i].exp_diff));
      chk("tbl_bout", 32'(out_bout), 32'(vecs[i].exp_bout));
      step();
    end

    // Streaming: 256 back-to-back random triples
    for (int i = 0; i < 256; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) chk("stream_no_bubble", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: two absorbed, third waits for release
    check_lat = 1'b0;
    out_ready = 1'b0;
    drive(8'h10, 8'h01, 1'b0);
    chk("bp_acc1", 32'(in_ready), 32'd1);
    step();
    drive(8'h20, 8'h02, 1'b1);
    chk("bp_acc2", 32'(in_ready), 32'd1);
    step();
    drive(8'h30, 8'h03, 1'b0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_diff", 32'(out_diff), 32'h0F);
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold_diff2", 32'(out_diff), 32'h0F);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_second", 32'(out_diff), 32'h1D);
    step();
    chk("bp_third", 32'(out_diff), 32'h2D);
    chk("bp_third_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with both stages full and an input offered
    out_ready = 1'b0;
    drive(8'h44, 8'h11, 1'b0);
    step();
    drive(8'h55, 8'h22, 1'b0);
    step();
    drive(8'h66, 8'h33, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      step();
      chk("flush_no_stale", 32'(out_valid), 32'd0);
    end
    check_lat = 1'b1;

    // Asynchronous reset with two transactions in flight
    out_ready = 1'b0;
    drive(8'h09, 8'h04, 1'b0);
    step();
    drive(8'h0A, 8'h05, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_before_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_diff", 32'(out_diff), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    #1;
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(8'h40, 8'h0F, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_not_early", 32'(out_valid), 32'd0);
    step();
    chk("ar_new_valid", 32'(out_valid), 32'd1);
    chk("ar_new_diff", 32'(out_diff), 32'h30);
    chk("ar_new_bout", 32'(out_bout), 32'd0);
    repeat (2) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
